// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer for the DDS core: steps fin from start_f to stop_f
// with a programmable dwell per point, in single, repeat or triangle mode.
module dds_sweep_ctrl #(
  parameter int FW = 24,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [FW-1:0] cfg_start_f,
  input  logic [FW-1:0] cfg_stop_f,
  input  logic [FW-1:0] cfg_step,
  input  logic [DW-1:0] cfg_dwell,
  input  logic [1:0]    cfg_mode,
  input  logic          start,
  input  logic          abort,
  output logic [FW-1:0] fin,
  output logic          fin_upd,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic {IDLE, DWELL} state_t;

  state_t        state, state_d;
  logic [FW-1:0] start_r, stop_r, step_r;
  logic [DW-1:0] dwell_r, cnt, cnt_d;
  logic [1:0]    mode_r;
  logic          dir_dn, dir_d;
  logic [FW-1:0] fin_d, up_nxt, dn_nxt;
  logic          upd_d, done_d, err_d;
  logic [FW:0]   up_sum, dn_dif;

  // One extra bit: carry out on the up leg, borrow (sign) on the down leg.
  assign up_sum = {1'b0, fin} + {1'b0, step_r};
  assign dn_dif = {1'b0, fin} - {1'b0, step_r};
  assign up_nxt = (up_sum > {1'b0, stop_r}) ? stop_r : up_sum[FW-1:0];
  assign dn_nxt = (dn_dif[FW] || (dn_dif[FW-1:0] < start_r)) ? start_r : dn_dif[FW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_r <= '0;
      stop_r  <= '0;
      step_r  <= '0;
      dwell_r <= '0;
      mode_r  <= '0;
    end else if (cfg_we && state == IDLE) begin
      start_r <= cfg_start_f;
      stop_r  <= cfg_stop_f;
      step_r  <= cfg_step;
      dwell_r <= cfg_dwell;
      mode_r  <= cfg_mode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      fin     <= '0;
      fin_upd <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      dir_dn  <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_d;
      fin     <= fin_d;
      fin_upd <= upd_d;
      busy    <= (state_d == DWELL);
      done    <= done_d;
      err     <= err_d;
      dir_dn  <= dir_d;
      cnt     <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    fin_d   = fin;
    upd_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    dir_d   = dir_dn;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          if (step_r == '0 || start_r > stop_r) begin
            err_d = 1'b1;
          end else begin
            state_d = DWELL;
            fin_d   = start_r;
            cnt_d   = dwell_r;
            dir_d   = 1'b0;
            upd_d   = 1'b1;
          end
        end
      end
      DWELL: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt != '0) begin
          cnt_d = cnt - 1'b1;
        end else begin
          cnt_d = dwell_r;
          upd_d = 1'b1;
          if (!dir_dn) begin
            if (fin == stop_r) begin
              case (mode_r)
                2'd1: fin_d = start_r;
                2'd2: begin
                  dir_d = 1'b1;
                  fin_d = dn_nxt;
                end
                default: begin
                  state_d = IDLE;
                  upd_d   = 1'b0;
                  done_d  = 1'b1;
                end
              endcase
            end else begin
              fin_d = up_nxt;
            end
          end else if (fin == start_r) begin
            // Turn around at the bottom without re-emitting start_f.
            dir_d = 1'b0;
            fin_d = up_nxt;
          end else begin
            fin_d = dn_nxt;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: sweep sequences, clamping, rejections,
// abort, reset and config locking, checked cycle by cycle.
module tb_dds_sweep_ctrl;
  localparam int FW = 24;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [FW-1:0] cfg_start_f = '0, cfg_stop_f = '0, cfg_step = '0;
  logic [DW-1:0] cfg_dwell = '0;
  logic [1:0]    cfg_mode = '0;
  logic          start = 1'b0, abort = 1'b0;
  logic [FW-1:0] fin;
  logic          fin_upd, busy, done, err;

  int n_chk = 0;
  int n_err = 0;
  int pts[8];

  dds_sweep_ctrl #(.FW(FW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we),
    .cfg_start_f(cfg_start_f), .cfg_stop_f(cfg_stop_f), .cfg_step(cfg_step),
    .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode), .start(start), .abort(abort),
    .fin(fin), .fin_upd(fin_upd), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input int f, input bit u, input bit b,
                     input bit d, input bit e);
    cmp({tag, ".fin"}, {8'h0, fin}, 32'(f));
    cmp({tag, ".fin_upd"}, {31'h0, fin_upd}, {31'h0, u});
    cmp({tag, ".busy"}, {31'h0, busy}, {31'h0, b});
    cmp({tag, ".done"}, {31'h0, done}, {31'h0, d});
    cmp({tag, ".err"}, {31'h0, err}, {31'h0, e});
  endtask

  task automatic cfg(input int sf, input int pf, input int st, input int dw, input int md);
    cfg_start_f = FW'(sf);
    cfg_stop_f  = FW'(pf);
    cfg_step    = FW'(st);
    cfg_dwell   = DW'(dw);
    cfg_mode    = 2'(md);
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  // Expects the points in pts[0..n-1], each held dwell+1 cycles from now.
  task automatic play(input string tag, input int n, input int dw, input bit fin_done);
    for (int i = 0; i < n; i++)
      for (int c = 0; c <= dw; c++) begin
        chk(tag, pts[i], c == 0, 1'b1, 1'b0, 1'b0);
        tick();
      end
    if (fin_done) chk({tag, ".end"}, pts[n-1], 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #12;
    chk("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();

    // Single sweep; back-to-back start in the done cycle.
    cfg(100, 130, 10, 2, 0);
    pts[0] = 100; pts[1] = 110; pts[2] = 120; pts[3] = 130;
    go();
    play("single", 4, 2, 1'b1);
    go();
    chk("b2b", 100, 1, 1, 0, 0);
    do_abort();
    chk("b2b_abort", 100, 0, 0, 0, 0);

    // Clamp to stop_f.
    cfg(100, 125, 10, 2, 0);
    pts[3] = 125;
    go();
    play("clamp", 4, 2, 1'b1);
    tick();
    chk("clamp_idle", 125, 0, 0, 0, 0);

    // No wrap at the top of the frequency range.
    cfg(32'hFFFFF0, 32'hFFFFFF, 32'h20, 0, 0);
    pts[0] = 32'hFFFFF0; pts[1] = 32'hFFFFFF;
    go();
    play("ovf", 2, 0, 1'b1);

    // Triangle, then abort mid-sweep.
    cfg(0, 20, 10, 0, 2);
    pts[0] = 0; pts[1] = 10; pts[2] = 20; pts[3] = 10;
    pts[4] = 0; pts[5] = 10; pts[6] = 20; pts[7] = 10;
    go();
    play("tri", 8, 0, 1'b0);
    chk("tri_wrap", 0, 1, 1, 0, 0);
    do_abort();
    chk("tri_abort", 0, 0, 0, 0, 0);

    // Repeat with no gap at the wrap.
    cfg(100, 130, 10, 2, 1);
    pts[0] = 100; pts[1] = 110; pts[2] = 120; pts[3] = 130;
    pts[4] = 100; pts[5] = 110;
    go();
    play("rep", 6, 2, 1'b0);
    chk("rep_next", 120, 1, 1, 0, 0);
    do_abort();
    chk("rep_abort", 120, 0, 0, 0, 0);

    // Rejections.
    cfg(100, 130, 0, 2, 0);
    go();
    chk("rej_step", 120, 0, 0, 0, 1);
    tick();
    chk("rej_step2", 120, 0, 0, 0, 0);
    cfg(50, 40, 10, 0, 0);
    go();
    chk("rej_order", 120, 0, 0, 0, 1);
    tick();
    chk("rej_order2", 120, 0, 0, 0, 0);
    cfg(100, 130, 10, 2, 0);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort", 120, 0, 0, 0, 0);
    tick();
    chk("start_abort2", 120, 0, 0, 0, 0);

    // Abort in the second dwell cycle of point 110.
    go();
    pts[0] = 100;
    play("ab110", 1, 2, 1'b0);
    chk("ab110_p1", 110, 1, 1, 0, 0);
    tick();
    chk("ab110_p2", 110, 0, 1, 0, 0);
    do_abort();
    chk("ab110_post", 110, 0, 0, 0, 0);
    tick();
    chk("ab110_nodone", 110, 0, 0, 0, 0);

    // cfg_we while busy is ignored.
    go();
    chk("lock_t1", 100, 1, 1, 0, 0);
    cfg(0, 10, 5, 0, 0);
    do_abort();
    go();
    chk("lock_p0", 100, 1, 1, 0, 0);
    tick(); tick(); tick();
    chk("lock_p1", 110, 1, 1, 0, 0);

    // Asynchronous reset mid-sweep, then config must be cleared.
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid", 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    go();
    chk("rst_cfg_clr", 0, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep sequencer for the DDS sine generator. It drives the 24-bit frequency word `fin` consumed by the phase-accumulator/ROM datapath, stepping it from a start frequency to a stop frequency with a programmable dwell per point. It supports single, repeating and triangle sweeps. The block sits between the front-panel/host configuration logic and the DDS core, and is the only writer of `fin`.

## Interface
- `FW`, 24: frequency-word width; must match DDS `fin`.
- `DW`, 16: dwell-counter width.

- `clk`  in  1  system clock, same domain as DDS core.
- `rst_n`  in  1  asynchronous active-low reset.
- `cfg_we`  in  1  latch configuration inputs; honoured only in IDLE.
- `cfg_start_f`  in  FW  first sweep point.
- `cfg_stop_f`  in  FW  last sweep point.
- `cfg_step`  in  FW  frequency increment per point.
- `cfg_dwell`  in  DW  extra cycles per point; each point is held `cfg_dwell+1` cycles.
- `cfg_mode`  in  2  0 = single up, 1 = repeat up, 2 = triangle, 3 = treated as 0.
- `start`  in  1  begin sweep; sampled in IDLE only.
- `abort`  in  1  stop sweep; sampled in every state.
- `fin`  out  FW  frequency word to the DDS core (registered).
- `fin_upd`  out  1  one-cycle pulse on the first cycle of each new point.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse at the end of a single sweep.
- `err`  out  1  one-cycle pulse when `start` is rejected.

## Operation
- Clock and reset: one clock `clk`. Reset is asynchronous and active-low on `rst_n`.
- Reset values: `fin`=0, `fin_upd`=0, `busy`=0, `done`=0, `err`=0, state=IDLE, direction=up, config registers=0.
- States:
  - IDLE: `cfg_we` latches all `cfg_*` into internal registers. `cfg_we` outside IDLE is ignored.
  - `start` in IDLE with `abort`=0:
    - If latched `step`==0 or `start_f` > `stop_f`: pulse `err`, remain in IDLE.
    - Otherwise go to DWELL with `fin`=`start_f`, dwell counter=`dwell`, direction=up, `fin_upd`=1, `busy`=1.
  - DWELL: counter decrements by 1 per cycle. When the counter is 0, the next point is computed and loaded in the same transition.
  - Up direction: next = `fin`+`step`, computed at FW+1 bits, so no wrap.
    - If `fin`==`stop_f`: end of up-leg.
    - Else if next > `stop_f`: next = `stop_f` (clamp). `stop_f` is always emitted.
  - End of up-leg:
    - Mode 0/3: go to IDLE, `done`=1, `busy`=0, `fin` holds `stop_f`.
    - Mode 1: next point is `start_f`.
    - Mode 2: direction = down; next = `stop_f`−`step`, clamped to `start_f`. If `start_f`==`stop_f`, next = `stop_f`.
  - Down direction (mode 2): next = `fin`−`step`, computed at FW+1 bits signed, clamped to `start_f`.
    - At `start_f`: direction = up; next = `start_f`+`step`, clamped.
    - Endpoints are never repeated consecutively, except when `start_f`==`stop_f`.
- `abort` (any state): next cycle IDLE, `busy`=0. `fin` holds its current value; no `done`, no `fin_upd`.
  - `abort` together with `start` in IDLE: abort wins; nothing happens and there is no `err`.
- Modes 1 and 2 run until `abort`. `done` never pulses in these modes.
- Reset mid-sweep: all outputs go immediately to their reset values. The latched config is cleared.

## Timing
- `start` sampled at edge t → `fin`=`start_f`, `fin_upd`=1, `busy`=1 from t+1.
- Each point holds for `dwell`+1 cycles. `fin_upd` is high only in the first of those cycles.
- `fin` changes only on edges where `fin_upd` rises; it is otherwise stable for the DDS.
- Mode 0 with N points: `done`=1 and `busy`=0 at t+1+N·(`dwell`+1), for exactly 1 cycle.
- `err`: 1 cycle at t+1.
- `abort` sampled at edge a → `busy`=0 at a+1.
- Back-to-back: a `start` is accepted in the cycle `done` is high, since the block is already IDLE.

## Test plan
- Single sweep: `start_f`=100, `stop_f`=130, `step`=10, `dwell`=2, mode 0 → `fin` = 100, 110, 120, 130, each held 3 cycles; `fin_upd` at t+1, t+4, t+7, t+10; `done` at t+13; `fin` stays 130.
- Clamp and overflow:
  - `stop_f`=125, otherwise as the single-sweep case → points 100, 110, 120, 125.
  - `start_f`=0xFFFFF0, `stop_f`=0xFFFFFF, `step`=0x20, `dwell`=0 → 0xFFFFF0, 0xFFFFFF, then `done`. No wrap to low values.
- Triangle: `start_f`=0, `stop_f`=20, `step`=10, `dwell`=0, mode 2 → sequence 0, 10, 20, 10, 0, 10, 20…, with `fin_upd` every cycle and `done` never asserted.
- Repeat: mode 1 with the single-sweep values → 100, 110, 120, 130, 100, 110…, with no gap cycle at the wrap.
- Rejections:
  - `step`=0, `start` → `err` at t+1; `busy`, `fin_upd` stay 0.
  - `start_f`=50, `stop_f`=40 → same response.
  - `start`+`abort` together → no response at all.
- Abort and reset:
  - Abort in the second dwell cycle of point 110 → `busy`=0 next cycle, `fin`=110 held, no `done`.
  - `rst_n` low mid-sweep → all outputs 0 immediately.
  - `cfg_we` while busy is ignored: the next sweep uses the old config.
